paddle_ai: RTL and testbench
============================

Name: paddle_ai

Overview:
- Computer opponent controller for Pong; drives the up/down command pins of a paddle position block.
- Observes ball vertical position, ball horizontal direction and the paddle's current position, and issues single-cycle up/down move pulses at a rate set by a step strobe.
- Has a reaction delay and a deadband so the opponent is beatable.
- Sits between the ball logic and the CPU-side paddle instance.

Parameters:
- HEIGHT, 20, paddle height in pixels; paddle occupies rows paddle_v .. paddle_v+HEIGHT-1.
- MAX_V, 240, exclusive upper vertical bound.
- MIN_V, 0, lower vertical bound.
- CENTER_V, (MAX_V+MIN_V-HEIGHT)/2 = 110, paddle_v rest position when the ball moves away.
- DEADBAND, 2, abs(error) <= DEADBAND produces no move.
- REACT_STEPS, 4, step strobes ignored after the ball turns toward this paddle; 0 = no delay.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = AI in control; 0 = outputs forced idle.
- step  in  1  one-cycle move strobe (e.g. frame tick).
- ball_v  in  9  ball vertical position.
- ball_toward  in  1  1 = ball moving horizontally toward this paddle.
- paddle_v  in  9  current paddle vertical position (low edge).
- up  out  1  one-cycle pulse; paddle_v increments by 1 on that clock.
- down  out  1  one-cycle pulse; paddle_v decrements by 1.
- busy  out  1  1 when state is TRACK or CENTER.

Behaviour:
- Reset (reset=0, async): state=IDLE, up=0, down=0, busy=0, react_cnt=0. All outputs are registered.
- States: IDLE, HOLD, TRACK, CENTER.
- Transitions, evaluated each clock and listed in priority order:
  - enable=0 → IDLE from any state; up/down are 0 from the next cycle.
  - IDLE & enable=1 → HOLD (react_cnt=0) if ball_toward=1, else CENTER.
  - HOLD & ball_toward=0 → CENTER.
  - HOLD & step=1: if react_cnt==REACT_STEPS-1 (or REACT_STEPS==0) → TRACK; else react_cnt+1. No pulse is issued in HOLD.
  - TRACK & ball_toward=0 → CENTER.
  - CENTER & ball_toward rising (registered previous value 0, now 1) → HOLD with react_cnt=0.
- Target, computed in 11-bit signed arithmetic:
  - TRACK: raw = ball_v - HEIGHT/2, clamped to [MIN_V, MAX_V-HEIGHT].
  - CENTER: CENTER_V.
  - error = target - paddle_v.
- Move, in TRACK or CENTER on a cycle with step=1 and no transition out on that cycle:
  - error > DEADBAND and paddle_v+HEIGHT < MAX_V → up=1 next cycle.
  - error < -DEADBAND and paddle_v > MIN_V → down=1 next cycle.
  - Otherwise no pulse.
- Latency: step sampled at edge N → pulse high during cycle N+1 only.
- up and down are never both 1.
- No pulse is issued on cycles where step=0.
- A state transition and step on the same cycle: the transition wins; no pulse on that step.
- busy is registered from the next state.

Decomposition:
- pong_pkg holds:
  - paddle_ai state enum (2-bit);
  - screen constants MAX_V, MIN_V, MAX_H, MIN_H;
  - position widths H_W=10, V_W=9.
- One sub-module: paddle_ai_target (combinational). Inputs: mode, ball_v, paddle_v. Outputs: clamped target and signed error plus move_up/move_dn qualifiers. This keeps the FSM file to state, counter and output registers only.

Test Plan:
1. Reset low mid-run with up=1 → up, down and busy go 0 immediately (async), without waiting for a clock edge; state=IDLE after release with enable=0.
2. enable=1, ball_toward=1, ball_v=200, paddle_v=100, step every 4 cycles → first 4 steps give no pulse (HOLD). The 5th step gives up=1 for exactly one cycle, one cycle after the step, and busy=1.
3. TRACK, ball_v=121, paddle_v=110 (error=1) → no pulse on any step. With paddle_v=107 (error=4) → down=0, up=1 on the next step.
4. TRACK, ball_v=239, paddle_v=220 → target clamps to 220, no up. With ball_v=0, paddle_v=0 → no down. No underflow into target ≥ 256.
5. TRACK, paddle_v=200, ball_toward falls on a step cycle → no pulse that step, state CENTER. Subsequent steps give down pulses until paddle_v=112, then none.
6. enable low in HOLD on the same cycle as step → no pulse, IDLE. Re-enable with ball_toward=1 → HOLD restarts with react_cnt=0 and needs a full 4 steps again.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong screen geometry, position widths and the paddle_ai state encoding.
package pong_pkg;

    localparam int H_W   = 10;
    localparam int V_W   = 9;
    localparam int MAX_V = 240;
    localparam int MIN_V = 0;
    localparam int MAX_H = 640;
    localparam int MIN_H = 0;

    // Encoding is fixed so older blocks decoding the raw 2-bit state keep working.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;
    localparam logic [1:0] ST_CENTER = 2'd3;

    typedef logic [1:0] ai_state_t;

endpackage

// File: rtl/paddle_ai_target.sv
// Combinational aim point for the AI paddle: clamped target, signed error and
// the up/down qualifiers that respect the deadband and the screen edges.
module paddle_ai_target
    import pong_pkg::*;
#(
    parameter int HEIGHT   = 20,
    parameter int DEADBAND = 2
) (
    input  logic [1:0]     mode,
    input  logic [V_W-1:0] ball_v,
    input  logic [V_W-1:0] paddle_v,
    output logic           move_up,
    output logic           move_dn
);

    localparam logic signed [10:0] HALF_S   = 11'(HEIGHT / 2);
    localparam logic signed [10:0] LO_S     = 11'(MIN_V);
    localparam logic signed [10:0] HI_S     = 11'(MAX_V - HEIGHT);
    localparam logic signed [10:0] CENTER_S = 11'((MAX_V + MIN_V - HEIGHT) / 2);
    localparam logic signed [10:0] DB_S     = 11'(DEADBAND);
    localparam logic signed [10:0] HGT_S    = 11'(HEIGHT);
    localparam logic signed [10:0] MAX_S    = 11'(MAX_V);

    logic signed [10:0] raw_s;
    logic signed [10:0] tgt_s;
    logic signed [10:0] pad_s;
    logic signed [10:0] error_s;

    // Target and move qualifiers; signed width keeps ball_v < HEIGHT/2 from wrapping.
    always_comb begin
        pad_s = $signed({2'b00, paddle_v});
        raw_s = $signed({2'b00, ball_v}) - HALF_S;
        if (mode == ST_TRACK) begin
            if (raw_s < LO_S) begin
                tgt_s = LO_S;
            end else if (raw_s > HI_S) begin
                tgt_s = HI_S;
            end else begin
                tgt_s = raw_s;
            end
        end else begin
            tgt_s = CENTER_S;
        end
        error_s = tgt_s - pad_s;
        move_up = (error_s > DB_S) && ((pad_s + HGT_S) < MAX_S);
        move_dn = (error_s < -DB_S) && (pad_s > LO_S);
    end

endmodule

// File: rtl/paddle_ai.sv
// Pong computer opponent: reaction-delayed tracking FSM issuing single-cycle
// up/down pulses on step strobes, returning to centre when the ball leaves.
module paddle_ai
    import pong_pkg::*;
#(
    parameter int HEIGHT      = 20,
    parameter int DEADBAND    = 2,
    parameter int REACT_STEPS = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic           step,
    input  logic [V_W-1:0] ball_v,
    input  logic           ball_toward,
    input  logic [V_W-1:0] paddle_v,
    output logic           up,
    output logic           down,
    output logic           busy
);

    localparam int              CNT_W      = (REACT_STEPS > 1) ? $clog2(REACT_STEPS) : 1;
    localparam logic [CNT_W-1:0] REACT_LAST = CNT_W'((REACT_STEPS > 0) ? REACT_STEPS - 1 : 0);
    localparam logic            NO_DELAY   = (REACT_STEPS == 0);

    ai_state_t        state_r;
    ai_state_t        state_s;
    logic [CNT_W-1:0] react_cnt_r;
    logic [CNT_W-1:0] react_cnt_s;
    logic             toward_prev_r;
    logic             move_ok_s;
    logic             move_up_s;
    logic             move_dn_s;
    logic             up_r;
    logic             down_r;
    logic             busy_r;

    paddle_ai_target #(
        .HEIGHT   (HEIGHT),
        .DEADBAND (DEADBAND)
    ) u_target (
        .mode     (state_r),
        .ball_v   (ball_v),
        .paddle_v (paddle_v),
        .move_up  (move_up_s),
        .move_dn  (move_dn_s)
    );

    // Next state and reaction counter; a move is allowed only when no transition is taken.
    always_comb begin
        state_s     = state_r;
        react_cnt_s = react_cnt_r;
        move_ok_s   = 1'b0;
        if (!enable) begin
            state_s     = ST_IDLE;
            react_cnt_s = CNT_W'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    react_cnt_s = CNT_W'(0);
                    if (ball_toward) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_CENTER;
                    end
                end
                ST_HOLD: begin
                    if (!ball_toward) begin
                        state_s = ST_CENTER;
                    end else if (step) begin
                        if (NO_DELAY || (react_cnt_r == REACT_LAST)) begin
                            state_s = ST_TRACK;
                        end else begin
                            react_cnt_s = react_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_TRACK: begin
                    if (!ball_toward) begin
                        state_s = ST_CENTER;
                    end else begin
                        move_ok_s = step;
                    end
                end
                ST_CENTER: begin
                    if (ball_toward && !toward_prev_r) begin
                        state_s     = ST_HOLD;
                        react_cnt_s = CNT_W'(0);
                    end else begin
                        move_ok_s = step;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    react_cnt_s = CNT_W'(0);
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            react_cnt_r   <= CNT_W'(0);
            toward_prev_r <= 1'b0;
            up_r          <= 1'b0;
            down_r        <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            react_cnt_r   <= react_cnt_s;
            toward_prev_r <= ball_toward;
            up_r          <= move_ok_s & move_up_s;
            down_r        <= move_ok_s & move_dn_s;
            busy_r        <= (state_s == ST_TRACK) || (state_s == ST_CENTER);
        end
    end

    assign up   = up_r;
    assign down = down_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_paddle_ai.sv
// Directed bench for paddle_ai: each step pushes its expected {up,down,busy}
// into a scoreboard that a negedge monitor pops in the following cycle.
module tb_paddle_ai;

    typedef struct packed {
        logic up;
        logic dn;
        logic busy;
    } exp_t;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       enable      = 1'b0;
    logic       step        = 1'b0;
    logic       ball_toward = 1'b0;
    logic [8:0] ball_v      = 9'd0;
    logic [8:0] paddle_v    = 9'd0;
    logic       up;
    logic       down;
    logic       busy;

    int    errors = 0;
    int    checks = 0;
    exp_t  exp_q[$];
    string name_q[$];
    exp_t  e_m;
    string n_m;
    logic  step_q = 1'b0;
    logic  done   = 1'b0;

    paddle_ai dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .step        (step),
        .ball_v      (ball_v),
        .ball_toward (ball_toward),
        .paddle_v    (paddle_v),
        .up          (up),
        .down        (down),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) step_q <= step;

    // Monitor: pulse window follows each sampled step; every other cycle must be quiet.
    always @(negedge clock) begin
        if (!done) begin
            if (step_q) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got up=%0b down=%0b busy=%0b with no expectation queued", up, down, busy);
                end else begin
                    e_m = exp_q.pop_front();
                    n_m = name_q.pop_front();
                    if ({up, down, busy} !== e_m) begin
                        errors++;
                        $display("FAIL %s: got up=%0b down=%0b busy=%0b, expected up=%0b down=%0b busy=%0b",
                                 n_m, up, down, busy, e_m.up, e_m.dn, e_m.busy);
                    end
                end
            end else begin
                checks++;
                if (up !== 1'b0 || down !== 1'b0) begin
                    errors++;
                    $display("FAIL no_step_pulse: got up=%0b down=%0b, expected both 0 at %0t", up, down, $time);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic step_vec(input string nm, input logic eu, input logic ed, input logic eb,
                            input logic tw, input logic en);
        @(posedge clock);
        #1;
        ball_toward = tw;
        enable      = en;
        step        = 1'b1;
        exp_q.push_back({eu, ed, eb});
        name_q.push_back(nm);
        @(posedge clock);
        #1;
        step = 1'b0;
    endtask

    task automatic do_step(input string nm, input logic eu, input logic ed, input logic eb);
        step_vec(nm, eu, ed, eb, ball_toward, enable);
    endtask

    initial begin
        #2 reset = 1'b0;
        #2;
        check("rst_up", up, 0);
        check("rst_down", down, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        idle(3);
        check("idle_disabled_busy", busy, 0);

        // Reaction delay: four ignored steps, then tracking toward ball_v=200.
        ball_v = 9'd200; paddle_v = 9'd100; ball_toward = 1'b1; enable = 1'b1;
        idle(2);
        check("hold_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            idle(3);
            do_step("hold_step", 1'b0, 1'b0, 1'b0);
        end
        idle(3);
        do_step("hold_last_step", 1'b0, 1'b0, 1'b1);
        idle(3);
        do_step("track_first_up", 1'b1, 1'b0, 1'b1);

        // Deadband.
        ball_v = 9'd121; paddle_v = 9'd110;
        do_step("deadband_err1_a", 1'b0, 1'b0, 1'b1);
        do_step("deadband_err1_b", 1'b0, 1'b0, 1'b1);
        paddle_v = 9'd107;
        do_step("err4_up", 1'b1, 1'b0, 1'b1);

        // Clamping at both screen edges.
        ball_v = 9'd239; paddle_v = 9'd220;
        do_step("clamp_top_no_up", 1'b0, 1'b0, 1'b1);
        paddle_v = 9'd210;
        do_step("clamp_top_up", 1'b1, 1'b0, 1'b1);
        ball_v = 9'd0; paddle_v = 9'd0;
        do_step("clamp_low_no_down", 1'b0, 1'b0, 1'b1);
        paddle_v = 9'd10;
        do_step("clamp_low_down", 1'b0, 1'b1, 1'b1);
        ball_v = 9'd5; paddle_v = 9'd3;
        do_step("low_ball_down", 1'b0, 1'b1, 1'b1);

        // Ball turns away on a step cycle, then centring from 200.
        ball_v = 9'd200; paddle_v = 9'd200;
        step_vec("toward_fall_step", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        do_step("center_dn_200", 1'b0, 1'b1, 1'b1);
        paddle_v = 9'd150;
        do_step("center_dn_150", 1'b0, 1'b1, 1'b1);
        paddle_v = 9'd113;
        do_step("center_dn_113", 1'b0, 1'b1, 1'b1);
        paddle_v = 9'd112;
        do_step("center_stop_112", 1'b0, 1'b0, 1'b1);
        paddle_v = 9'd108;
        do_step("center_band_108", 1'b0, 1'b0, 1'b1);
        paddle_v = 9'd107;
        do_step("center_up_107", 1'b1, 1'b0, 1'b1);

        // Rising ball_toward in CENTER restarts the reaction delay.
        ball_v = 9'd200; paddle_v = 9'd100; ball_toward = 1'b1;
        idle(2);
        check("center_to_hold_busy", busy, 0);
        do_step("hold_again", 1'b0, 1'b0, 1'b0);
        step_vec("enable_off_step", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("disabled_busy", busy, 0);
        enable = 1'b1;
        idle(2);
        for (int i = 0; i < 3; i++) begin
            do_step("rehold_step", 1'b0, 1'b0, 1'b0);
        end
        do_step("rehold_last", 1'b0, 1'b0, 1'b1);
        do_step("rehold_up", 1'b1, 1'b0, 1'b1);

        // Async reset while the up pulse is high.
        #5;
        check("pre_reset_up", up, 1);
        reset = 1'b0;
        #1;
        check("async_rst_up", up, 0);
        check("async_rst_down", down, 0);
        check("async_rst_busy", busy, 0);
        enable = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        idle(3);
        check("post_reset_busy", busy, 0);
        check("post_reset_up", up, 0);

        idle(2);
        check("sb_empty", exp_q.size(), 0);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
